// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   lock_state_e : states of the lock-detect FSM in clk_div_multi
//   ch_width()   : width of a channel index for a given channel count
//   wc_width()   : width of a saturating wrap counter for a given lock period count
//   cfg_legal()  : range check applied to every accepted configuration request
package clk_div_pkg;

   typedef enum logic [1:0] {
      LK_RESET  = 2'd0,
      LK_COUNT  = 2'd1,
      LK_LOCKED = 2'd2
   } lock_state_e;

   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   function automatic int unsigned wc_width(input int unsigned periods);
      return (periods > 0) ? $clog2(periods + 1) : 1;
   endfunction

   // A request is legal when the divisor is non-zero and the channel exists.
   function automatic logic cfg_legal(input int unsigned ch,
                                      input int unsigned num_ch,
                                      input logic        div_zero);
      return !div_zero && (ch < num_ch);
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter 0..div-1, duty compare, clock-enable strobe,
// glitch-free divisor update at wrap, phase load on sync, saturating wrap count.
//   refclk    : reference clock (rising edge)
//   rst_n     : async active-low reset
//   pend_here : a pending divisor targets this channel
//   pend_div  : the pending divisor value
//   phase_we  : store phase_in as this channel's phase
//   phase_in  : phase offset in refclk cycles
//   sync      : load counter with stored phase (clamped to div-1)
//   clr_wrap  : clear the wrap counter
//   outclk    : divided clock (high while cnt < ceil(div/2))
//   clk_en    : one-cycle strobe per divided period
//   wrap      : counter wraps at the coming edge (not during sync)
//   sat       : wrap counter has reached LOCK_PERIODS
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W        = 16,
   parameter int unsigned DEFAULT_DIV  = 3,
   parameter int unsigned LOCK_PERIODS = 2
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pend_here,
   input  logic [DIV_W-1:0] pend_div,
   input  logic             phase_we,
   input  logic [DIV_W-1:0] phase_in,
   input  logic             sync,
   input  logic             clr_wrap,
   output logic             outclk,
   output logic             clk_en,
   output logic             wrap,
   output logic             sat
);

   localparam int unsigned WC_W = wc_width(LOCK_PERIODS);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] phase;
   logic [WC_W-1:0]  wcnt;
   logic             at_top;
   logic [DIV_W:0]   half;
   logic [DIV_W-1:0] phase_eff;

   assign at_top    = (cnt == div - DIV_W'(1));
   assign wrap      = at_top & ~sync;
   // One extra bit so div = 2**DIV_W-1 does not overflow the round-up.
   assign half      = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
   // Out-of-range phase clamps to the last count instead of wrapping.
   assign phase_eff = (phase >= div) ? (div - DIV_W'(1)) : phase;
   assign sat       = (wcnt == WC_W'(LOCK_PERIODS));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         div    <= DIV_W'(DEFAULT_DIV);
         phase  <= '0;
         wcnt   <= '0;
         outclk <= 1'b0;
         clk_en <= 1'b0;
      end else begin
         outclk <= ({1'b0, cnt} < half);
         clk_en <= at_top;
         if (phase_we) phase <= phase_in;

         if (sync) begin
            cnt <= phase_eff;
         end else if (at_top) begin
            cnt <= '0;
            // Divisor only changes on a period boundary, so no runt pulses.
            if (pend_here) div <= pend_div;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end

         if (clr_wrap)          wcnt <= '0;
         else if (wrap && !sat) wcnt <= wcnt + WC_W'(1);
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with run-time reprogramming and lock detect.
//   refclk    : reference clock, all logic on rising edge
//   rst_n     : async active-low reset
//   cfg_valid : configuration request         cfg_ready : pending slot free
//   cfg_ch    : target channel                cfg_div   : new divisor (0 illegal)
//   cfg_phase : phase offset used on sync     cfg_err   : 1-cycle pulse, request rejected
//   sync      : realign all channels to their stored phase
//   outclk    : divided clocks                clk_en    : 1-cycle strobe per period
//   locked    : every channel has completed LOCK_PERIODS wraps since the last change
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH       = 4,
   parameter  int unsigned DIV_W        = 16,
   parameter  int unsigned DEFAULT_DIV  = 3,
   parameter  int unsigned LOCK_PERIODS = 2,
   localparam int unsigned CH_W         = ch_width(NUM_CH)
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_err,
   input  logic              sync,
   output logic [NUM_CH-1:0] outclk,
   output logic [NUM_CH-1:0] clk_en,
   output logic              locked
);

   logic              accept;
   logic              legal;
   logic              apply;
   logic              clr_wrap;
   logic [CH_W-1:0]   pend_ch;
   logic [DIV_W-1:0]  pend_div;
   logic [NUM_CH-1:0] pend_sel;
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] sat;
   lock_state_e       state;
   lock_state_e       state_nxt;

   assign accept   = cfg_valid & cfg_ready;
   assign legal    = cfg_legal(32'(cfg_ch), NUM_CH, cfg_div == '0);
   // The pending divisor lands when its channel wraps; sync suppresses wraps.
   assign apply    = |(wrap & pend_sel);
   assign clr_wrap = apply | sync;

   // cfg_ready doubles as "pending register empty".
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
         pend_ch   <= '0;
         pend_div  <= '0;
      end else begin
         cfg_err <= accept & ~legal;
         if (accept && legal) begin
            cfg_ready <= 1'b0;
            pend_ch   <= cfg_ch;
            pend_div  <= cfg_div;
         end else if (apply) begin
            cfg_ready <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign pend_sel[i] = ~cfg_ready & (pend_ch == CH_W'(i));

      clk_div_ch #(
         .DIV_W        (DIV_W),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .LOCK_PERIODS (LOCK_PERIODS)
      ) u_ch (
         .refclk    (refclk),
         .rst_n     (rst_n),
         .pend_here (pend_sel[i]),
         .pend_div  (pend_div),
         .phase_we  (accept & legal & (cfg_ch == CH_W'(i))),
         .phase_in  (cfg_phase),
         .sync      (sync),
         .clr_wrap  (clr_wrap),
         .outclk    (outclk[i]),
         .clk_en    (clk_en[i]),
         .wrap      (wrap[i]),
         .sat       (sat[i])
      );
   end

   // NOTE: next state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         LK_RESET:  state_nxt = LK_COUNT;
         LK_COUNT:  if (!clr_wrap && (&sat)) state_nxt = LK_LOCKED;
         LK_LOCKED: if (clr_wrap) state_nxt = LK_COUNT;
         default:   state_nxt = LK_RESET;
      endcase
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= LK_RESET;
         locked <= 1'b0;
      end else begin
         state  <= state_nxt;
         locked <= (state_nxt == LK_LOCKED);
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi. A reference model describes each channel
// by an anchor (time, position) pair and derives the counter position with modulo
// arithmetic; lock is "every channel has wrapped LOCK_PERIODS times since the last
// change and no change is happening now". Expected outputs are queued every cycle
// and a separate monitor compares them against the DUT.
module tb_clk_div_multi;

   localparam int NCH     = 5;
   localparam int DIV_W   = 16;
   localparam int DEF_DIV = 3;
   localparam int LOCK_P  = 2;
   localparam int CH_W    = $clog2(NCH);

   typedef struct packed {
      logic [NCH-1:0] outclk;
      logic [NCH-1:0] clk_en;
      logic           locked;
      logic           ready;
      logic           err;
   } exp_t;

   localparam exp_t RST_EXP = '{outclk: '0, clk_en: '0, locked: 1'b0,
                                ready: 1'b1, err: 1'b0};

   logic             refclk    = 1'b0;
   logic             rst_n     = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CH_W-1:0]  cfg_ch    = '0;
   logic [DIV_W-1:0] cfg_div   = '0;
   logic [DIV_W-1:0] cfg_phase = '0;
   logic             sync      = 1'b0;
   logic             cfg_ready;
   logic             cfg_err;
   logic [NCH-1:0]   outclk;
   logic [NCH-1:0]   clk_en;
   logic             locked;

   clk_div_multi #(
      .NUM_CH       (NCH),
      .DIV_W        (DIV_W),
      .DEFAULT_DIV  (DEF_DIV),
      .LOCK_PERIODS (LOCK_P)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .sync      (sync),
      .outclk    (outclk),
      .clk_en    (clk_en),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_div   [NCH];
   int m_phase [NCH];
   int m_t0    [NCH];
   int m_p0    [NCH];
   int m_wraps [NCH];
   int cyc;
   bit m_pend;
   bit m_ready;
   int m_pend_ch;
   int m_pend_div;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_div[i]   = DEF_DIV;
         m_phase[i] = 0;
         m_t0[i]    = 0;
         m_p0[i]    = 0;
         m_wraps[i] = 0;
      end
      cyc        = 0;
      m_pend     = 0;
      m_ready    = 1;
      m_pend_ch  = 0;
      m_pend_div = 0;
   endtask

   task automatic model_step();
      int   pos [NCH];
      bit   wev [NCH];
      bit   apply, clear, all_sat, acc, legal;
      int   t;
      exp_t e;
      t       = cyc + 1;
      all_sat = 1;
      for (int i = 0; i < NCH; i++) begin
         pos[i]      = (m_p0[i] + (cyc - m_t0[i])) % m_div[i];
         e.outclk[i] = (pos[i] < (m_div[i] + 1) / 2);
         e.clk_en[i] = (pos[i] == m_div[i] - 1);
         wev[i]      = (pos[i] == m_div[i] - 1) && !sync;
         if (m_wraps[i] < LOCK_P) all_sat = 0;
      end
      apply    = m_pend && wev[m_pend_ch];
      clear    = apply || sync;
      e.locked = all_sat && !clear;
      acc      = cfg_valid && m_ready;
      legal    = (cfg_div != 0) && (int'(cfg_ch) < NCH);
      e.err    = acc && !legal;
      for (int i = 0; i < NCH; i++) begin
         if (sync) begin
            m_t0[i] = t;
            m_p0[i] = (m_phase[i] >= m_div[i]) ? m_div[i] - 1 : m_phase[i];
         end else if (apply && i == m_pend_ch) begin
            m_div[i] = m_pend_div;
            m_t0[i]  = t;
            m_p0[i]  = 0;
         end
         if (clear)       m_wraps[i] = 0;
         else if (wev[i]) m_wraps[i]++;
      end
      if (apply) begin
         m_pend  = 0;
         m_ready = 1;
      end
      if (acc && legal) begin
         m_pend            = 1;
         m_ready           = 0;
         m_pend_ch         = int'(cfg_ch);
         m_pend_div        = int'(cfg_div);
         m_phase[m_pend_ch] = int'(cfg_phase);
      end
      e.ready = m_ready;
      cyc     = t;
      exp_q.push_back(e);
   endtask

   always @(negedge rst_n) begin
      model_reset();
      exp_q.delete();
   end

   always @(posedge refclk) begin
      if (!rst_n) begin
         model_reset();
         exp_q.push_back(RST_EXP);
      end else begin
         model_step();
      end
   end

   // ---------------- monitor ----------------
   always @(negedge refclk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("outclk",    32'(outclk),    32'(e.outclk));
         check("clk_en",    32'(clk_en),    32'(e.clk_en));
         check("locked",    32'(locked),    32'(e.locked));
         check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
         check("cfg_err",   32'(cfg_err),   32'(e.err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!cfg_ready && k < 300) begin
         tick();
         k++;
      end
      check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
   endtask

   task automatic cfg_req(input int ch, input int dv, input int ph);
      wait_ready();
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(dv);
      cfg_phase = DIV_W'(ph);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   initial begin
      // Reset release with default divisors; lock after two wraps.
      tick(3);
      rst_n = 1'b1;
      tick(12);

      // Reprogram ch1 to div 8 mid-period.
      tick(1);
      cfg_req(1, 8, 0);
      tick(30);

      // Illegal requests: zero divisor, nonexistent channel.
      cfg_req(2, 0, 0);
      tick(3);
      cfg_req(NCH, 4, 0);
      tick(5);

      // Phase offsets then sync; phase 5 with div 3 clamps to 2.
      cfg_req(0, 3, 0);
      wait_ready();
      cfg_req(1, 3, 1);
      wait_ready();
      cfg_req(2, 3, 2);
      wait_ready();
      pulse_sync();
      tick(8);
      cfg_req(3, 3, 5);
      wait_ready();
      pulse_sync();
      tick(8);

      // div 1 and div 2 on ch3.
      cfg_req(3, 1, 0);
      wait_ready();
      tick(10);
      cfg_req(3, 2, 0);
      wait_ready();
      tick(10);

      // Reset asserted while a request is pending.
      cfg_req(0, 20, 0);
      wait_ready();
      tick(2);
      cfg_req(0, 7, 0);
      tick(3);
      rst_n = 1'b0;
      #1;
      check("rst_outclk",    32'(outclk),    32'd0);
      check("rst_clk_en",    32'(clk_en),    32'd0);
      check("rst_locked",    32'(locked),    32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_cfg_err",   32'(cfg_err),   32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(15);

      // Randomized traffic.
      for (int c = 0; c < 2000; c++) begin
         cfg_valid = ($urandom_range(0, 11) == 0);
         cfg_ch    = CH_W'($urandom_range(0, (1 << CH_W) - 1));
         cfg_div   = DIV_W'($urandom_range(0, 10));
         cfg_phase = DIV_W'($urandom_range(0, 12));
         sync      = ($urandom_range(0, 79) == 0);
         rst_n     = ($urandom_range(0, 799) != 0);
         tick();
      end
      cfg_valid = 1'b0;
      sync      = 1'b0;
      rst_n     = 1'b1;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
